// File: rtl/weight_buffer_loader.sv
// Write-side sequencer for the weight buffer array: turns a valid/ready stream of
// packed kernel words into port-A writes, filling banks slot-first and bank-major.
module weight_buffer_loader #(
    parameter int TN         = 4,
    parameter int TM         = 16,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = $clog2(TM),
    parameter int ADDR_EXT   = $clog2(TN) + 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [ADDR_WIDTH:0]            num_kernels,
    input  logic [DATA_WIDTH-1:0]          in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic                           ena,
    output logic                           wea,
    output logic [ADDR_EXT+ADDR_WIDTH-1:0] addra,
    output logic [DATA_WIDTH-1:0]          dia,
    output logic                           busy,
    output logic                           done
);

    localparam int BANK_W = $clog2(TN);
    localparam int PAD_W  = ADDR_EXT - BANK_W;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FIN
    } state_e;

    state_e                          state_q;
    logic [BANK_W-1:0]               bank_q;
    logic [ADDR_WIDTH-1:0]           slot_q;
    logic [ADDR_WIDTH:0]             nk_q;
    logic [ADDR_WIDTH:0]             nk_d;
    logic                            ena_q;
    logic                            wea_q;
    logic [ADDR_EXT+ADDR_WIDTH-1:0]  addra_q;
    logic [DATA_WIDTH-1:0]           dia_q;
    logic                            busy_q;
    logic                            done_q;

    logic accept;
    logic last_slot;
    logic last_bank;

    // Requests larger than a bank's capacity are clamped rather than wrapped.
    assign nk_d = (num_kernels > (ADDR_WIDTH+1)'(TM)) ? (ADDR_WIDTH+1)'(TM) : num_kernels;

    assign in_ready  = (state_q == LOAD);
    assign accept    = in_valid & in_ready;
    assign last_slot = ({1'b0, slot_q} == (nk_q - (ADDR_WIDTH+1)'(1)));
    assign last_bank = (bank_q == BANK_W'(TN - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bank_q  <= '0;
            slot_q  <= '0;
            nk_q    <= '0;
            ena_q   <= 1'b0;
            wea_q   <= 1'b0;
            addra_q <= '0;
            dia_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout, so every branch sees this cycle's state
            // and counters regardless of statement order; later assignments win.
            ena_q  <= 1'b0;
            wea_q  <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        bank_q <= '0;
                        slot_q <= '0;
                        nk_q   <= nk_d;
                        busy_q <= 1'b1;
                        if (num_kernels == '0) begin
                            state_q <= FIN;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        ena_q   <= 1'b1;
                        wea_q   <= 1'b1;
                        dia_q   <= in_data;
                        addra_q <= {{PAD_W{1'b0}}, bank_q, slot_q};
                        if (last_slot) begin
                            slot_q <= '0;
                            if (last_bank) begin
                                state_q <= FIN;
                                done_q  <= 1'b1;
                            end else begin
                                bank_q <= bank_q + BANK_W'(1);
                            end
                        end else begin
                            slot_q <= slot_q + ADDR_WIDTH'(1);
                        end
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ena   = ena_q;
    assign wea   = wea_q;
    assign addra = addra_q;
    assign dia   = dia_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_weight_buffer_loader.sv
// Directed bench for weight_buffer_loader: a negedge monitor logs accepts, writes and
// done pulses; each test task drives one load and compares the log to hand-derived values.
module tb_weight_buffer_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [4:0]  num_kernels;
    logic [63:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        ena;
    logic        wea;
    logic [6:0]  addra;
    logic [63:0] dia;
    logic        busy;
    logic        done;

    int n_asserts = 0;
    int n_fail    = 0;

    weight_buffer_loader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .num_kernels (num_kernels),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .ena         (ena),
        .wea         (wea),
        .addra       (addra),
        .dia         (dia),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          acc_cyc[$];
    int          wr_cyc[$];
    logic [6:0]  wr_addr[$];
    logic [63:0] wr_data[$];
    int          done_cnt;
    int          done_cyc;
    int          busy_fall_cyc;
    int          ew_err;
    int          start_cyc;
    logic        busy_prev = 1'b0;

    always @(negedge clk) begin
        if (in_valid && in_ready) acc_cyc.push_back(cyc);
        if (ena) begin
            wr_cyc.push_back(cyc);
            wr_addr.push_back(addra);
            wr_data.push_back(dia);
        end
        if (ena !== wea) ew_err++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (busy_prev && !busy) busy_fall_cyc = cyc;
        busy_prev = busy;
    end

    function automatic logic [6:0] exp_addr(input int i, input int nk);
        return 7'(((i / nk) << 4) | (i % nk));
    endfunction

    function automatic logic [75:0] outs();
        return {in_ready, ena, wea, addra, dia, busy, done};
    endfunction

    task automatic clear_mon();
        acc_cyc.delete();
        wr_cyc.delete();
        wr_addr.delete();
        wr_data.delete();
        done_cnt      = 0;
        done_cyc      = -1;
        busy_fall_cyc = -1;
        ew_err        = 0;
    endtask

    // Drives one load; bubble gives in_valid pattern 1,0,0 repeating.
    task automatic run_load(input int nk_in, input int nbeats, input bit bubble,
                            input int restart_at, input int abort_at);
        int beat = 0;
        int p = 0;
        int guard = 0;
        int tgt;
        bit acc;
        clear_mon();
        @(posedge clk); #1;
        start       = 1'b1;
        num_kernels = nk_in[4:0];
        start_cyc   = cyc;
        @(posedge clk); #1;
        start       = 1'b0;
        num_kernels = 5'd1;
        tgt = (abort_at >= 0) ? abort_at : nbeats;
        while (beat < tgt && guard < 400) begin
            in_valid = bubble ? (p % 3 == 0) : 1'b1;
            in_data  = 64'(beat);
            start    = (beat == restart_at);
            acc      = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) beat++;
            p++;
            guard++;
        end
        start    = 1'b0;
        in_valid = 1'b0;
        n_asserts++;
        if (beat != tgt) begin
            n_fail++;
            $display("FAIL beat_timeout: accepted %0d beats, required %0d", beat, tgt);
        end
        if (abort_at < 0) begin
            repeat (4) @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        start       = 1'b0;
        num_kernels = '0;
        in_data     = '0;
        in_valid    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_asserts++;
        if (outs() !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0", outs());
        end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_asserts++;
        if (outs() !== '0) begin
            n_fail++;
            $display("FAIL idle_outputs: got %h required 0", outs());
        end
    endtask

    task automatic test_full_load();
        run_load(16, 64, 1'b0, -1, -1);
        n_asserts++;
        if (wr_addr.size() != 64) begin
            n_fail++;
            $display("FAIL full_write_count: got %0d required 64", wr_addr.size());
        end
        for (int i = 0; i < wr_addr.size() && i < 64 && i < acc_cyc.size(); i++) begin
            n_asserts++;
            if (wr_addr[i] !== exp_addr(i, 16) || wr_data[i] !== 64'(i)) begin
                n_fail++;
                $display("FAIL full_write[%0d]: got addr %h data %0h required addr %h data %0h",
                         i, wr_addr[i], wr_data[i], exp_addr(i, 16), i);
            end
            n_asserts++;
            if (wr_cyc[i] != acc_cyc[i] + 1 || wr_cyc[i] != wr_cyc[0] + i) begin
                n_fail++;
                $display("FAIL full_timing[%0d]: write cycle %0d, accept cycle %0d, first write %0d",
                         i, wr_cyc[i], acc_cyc[i], wr_cyc[0]);
            end
        end
        n_asserts++;
        if (done_cnt != 1 || wr_cyc.size() == 0 || done_cyc != wr_cyc[wr_cyc.size()-1]) begin
            n_fail++;
            $display("FAIL full_done: got %0d pulses at cycle %0d, required 1 with last write", done_cnt, done_cyc);
        end
        n_asserts++;
        if (busy_fall_cyc != done_cyc + 1) begin
            n_fail++;
            $display("FAIL full_busy_fall: got cycle %0d required %0d", busy_fall_cyc, done_cyc + 1);
        end
        n_asserts++;
        if (ew_err != 0) begin
            n_fail++;
            $display("FAIL ena_wea_match: got %0d disagreements required 0", ew_err);
        end
    endtask

    task automatic test_partial_load();
        logic [6:0] exp_p[12] = '{7'h00, 7'h01, 7'h02, 7'h10, 7'h11, 7'h12,
                                  7'h20, 7'h21, 7'h22, 7'h30, 7'h31, 7'h32};
        run_load(3, 12, 1'b0, -1, -1);
        n_asserts++;
        if (wr_addr.size() != 12) begin
            n_fail++;
            $display("FAIL partial_write_count: got %0d required 12", wr_addr.size());
        end
        for (int i = 0; i < wr_addr.size() && i < 12; i++) begin
            n_asserts++;
            if (wr_addr[i] !== exp_p[i]) begin
                n_fail++;
                $display("FAIL partial_addr[%0d]: got %h required %h", i, wr_addr[i], exp_p[i]);
            end
        end
        n_asserts++;
        if (done_cnt != 1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL partial_done: got %0d pulses in_ready %b, required 1 pulse in_ready 0",
                     done_cnt, in_ready);
        end
    endtask

    task automatic test_backpressure();
        logic [6:0] exp_b[8] = '{7'h00, 7'h01, 7'h10, 7'h11, 7'h20, 7'h21, 7'h30, 7'h31};
        run_load(2, 8, 1'b1, -1, -1);
        n_asserts++;
        if (wr_addr.size() != 8 || acc_cyc.size() != 8) begin
            n_fail++;
            $display("FAIL bubble_count: got %0d writes %0d accepts required 8", wr_addr.size(), acc_cyc.size());
        end
        for (int i = 0; i < wr_addr.size() && i < 8 && i < acc_cyc.size(); i++) begin
            n_asserts++;
            if (wr_addr[i] !== exp_b[i] || wr_data[i] !== 64'(i) || wr_cyc[i] != acc_cyc[i] + 1) begin
                n_fail++;
                $display("FAIL bubble_write[%0d]: got addr %h data %0h cycle %0d required addr %h data %0h cycle %0d",
                         i, wr_addr[i], wr_data[i], wr_cyc[i], exp_b[i], i, acc_cyc[i] + 1);
            end
            if (i > 0) begin
                n_asserts++;
                if (wr_cyc[i] - wr_cyc[i-1] != 3) begin
                    n_fail++;
                    $display("FAIL bubble_gap[%0d]: got %0d cycles required 3", i, wr_cyc[i] - wr_cyc[i-1]);
                end
            end
        end
    endtask

    task automatic test_zero_kernels();
        run_load(0, 0, 1'b0, -1, -1);
        n_asserts++;
        if (wr_addr.size() != 0) begin
            n_fail++;
            $display("FAIL zero_writes: got %0d required 0", wr_addr.size());
        end
        n_asserts++;
        if (done_cnt != 1 || done_cyc != start_cyc + 1) begin
            n_fail++;
            $display("FAIL zero_done: got %0d pulses at cycle %0d required 1 at %0d",
                     done_cnt, done_cyc, start_cyc + 1);
        end
    endtask

    task automatic test_clamp();
        logic [6:0] hi = '0;
        run_load(20, 64, 1'b0, -1, -1);
        n_asserts++;
        if (wr_addr.size() != 64 || done_cnt != 1) begin
            n_fail++;
            $display("FAIL clamp_count: got %0d writes %0d done required 64 and 1", wr_addr.size(), done_cnt);
        end
        for (int i = 0; i < wr_addr.size(); i++) begin
            if (wr_addr[i] > hi) hi = wr_addr[i];
            if (i < 64) begin
                n_asserts++;
                if (wr_addr[i] !== exp_addr(i, 16)) begin
                    n_fail++;
                    $display("FAIL clamp_addr[%0d]: got %h required %h", i, wr_addr[i], exp_addr(i, 16));
                end
            end
        end
        n_asserts++;
        if (hi !== 7'h3F) begin
            n_fail++;
            $display("FAIL clamp_max_addr: got %h required 3f", hi);
        end
    endtask

    task automatic test_start_ignored();
        run_load(16, 64, 1'b0, 5, -1);
        n_asserts++;
        if (wr_addr.size() != 64 || done_cnt != 1) begin
            n_fail++;
            $display("FAIL restart_count: got %0d writes %0d done required 64 and 1", wr_addr.size(), done_cnt);
        end
        for (int i = 0; i < wr_addr.size() && i < 64; i++) begin
            n_asserts++;
            if (wr_addr[i] !== exp_addr(i, 16) || wr_data[i] !== 64'(i)) begin
                n_fail++;
                $display("FAIL restart_write[%0d]: got addr %h data %0h required addr %h data %0h",
                         i, wr_addr[i], wr_data[i], exp_addr(i, 16), i);
            end
        end
    endtask

    task automatic test_async_reset();
        run_load(16, 64, 1'b0, -1, 10);
        n_asserts++;
        if (ena !== 1'b1 || addra !== 7'h09) begin
            n_fail++;
            $display("FAIL pre_reset_write: got ena %b addr %h required 1 and 09", ena, addra);
        end
        #1 rst_n = 1'b0;
        #1;
        n_asserts++;
        if (outs() !== '0) begin
            n_fail++;
            $display("FAIL async_reset_outputs: got %h required 0", outs());
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_load(2, 8, 1'b0, -1, -1);
        n_asserts++;
        if (wr_addr.size() != 8 || wr_addr[0] !== 7'h00 || done_cnt != 1) begin
            n_fail++;
            $display("FAIL post_reset_load: got %0d writes first addr %h done %0d required 8, 00, 1",
                     wr_addr.size(), (wr_addr.size() > 0) ? wr_addr[0] : 7'h7F, done_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_partial_load();
        test_backpressure();
        test_zero_kernels();
        test_clamp();
        test_start_ignored();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
